// File: rtl/kc_ls1u_intc.sv
// Prioritised, maskable interrupt controller for the KC_LS1u_plus core.
// Edge/level sources feed a pending vector; a three-state handshake presents one INT with a latched code and vector.
module kc_ls1u_intc #(
    parameter  int NUM_IRQ         = 8,
    parameter  int ADDR_W          = 24,
    parameter  int VEC_STRIDE_LOG2 = 2,
    localparam int CODE_W          = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_i,
    input  logic [ADDR_W-1:0]   ivt_base_i,
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_addr_i,
    input  logic [NUM_IRQ-1:0]  cfg_wdata_i,
    output logic [NUM_IRQ-1:0]  cfg_rdata_o,
    output logic                int_o,
    input  logic                int_ack_i,
    input  logic                eoi_i,
    output logic [CODE_W-1:0]   intcode_o,
    output logic [ADDR_W-1:0]   ivec_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_IRQ-1:0]  r_mask;
    logic [NUM_IRQ-1:0]  r_edge;
    logic [NUM_IRQ-1:0]  r_pend;
    logic [NUM_IRQ-1:0]  r_irqPrev;
    logic [CODE_W-1:0]   r_code;
    logic                r_int;

    logic [NUM_IRQ-1:0]  w_eligible;
    logic [NUM_IRQ-1:0]  w_pendW1c;
    logic [NUM_IRQ-1:0]  w_ackClr;
    logic [NUM_IRQ-1:0]  w_edgeSet;
    logic [NUM_IRQ-1:0]  w_pendNext;
    logic                w_ackHit;
    logic                w_anyEligible;
    logic                w_codeEligible;
    logic [CODE_W-1:0]   w_topCode;
    logic [ADDR_W-1:0]   w_offset;
    logic [NUM_IRQ-1:0]  w_status;

    assign w_eligible     = r_pend & r_mask;
    assign w_anyEligible  = |w_eligible;
    assign w_codeEligible = w_eligible[r_code];
    assign w_ackHit       = (r_state == S_REQ) && int_ack_i;
    assign w_pendW1c      = (cfg_we_i && (cfg_addr_i == 2'd2)) ? cfg_wdata_i : '0;
    assign w_edgeSet      = irq_i & ~r_irqPrev;

    always_comb begin
        w_ackClr = '0;
        if (w_ackHit) begin
            w_ackClr[r_code] = 1'b1;
        end
    end

    // Edge sources: a fresh rise beats any clear in the same cycle. Level sources just track the input.
    assign w_pendNext = (r_edge & (w_edgeSet | (r_pend & ~(w_ackClr | w_pendW1c))))
                      | (~r_edge & irq_i);

    // Scan from the top down so the lowest eligible index is the last to win.
    always_comb begin
        w_topCode = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_topCode = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask    <= '0;
            r_edge    <= '0;
            r_pend    <= '0;
            r_irqPrev <= '0;
        end else begin
            r_pend    <= w_pendNext;
            r_irqPrev <= irq_i;
            if (cfg_we_i && (cfg_addr_i == 2'd0)) begin
                r_mask <= cfg_wdata_i;
            end
            if (cfg_we_i && (cfg_addr_i == 2'd1)) begin
                r_edge <= cfg_wdata_i;
            end
        end
    end

    // Request handshake; the code stays frozen from grant until end-of-interrupt, so no preemption.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_int   <= 1'b0;
            r_code  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyEligible) begin
                        r_state <= S_REQ;
                        r_int   <= 1'b1;
                        r_code  <= w_topCode;
                    end
                end
                S_REQ: begin
                    if (int_ack_i) begin
                        r_state <= S_SERVICE;
                        r_int   <= 1'b0;
                    end else if (!w_codeEligible) begin
                        r_state <= S_IDLE;
                        r_int   <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    r_int <= 1'b0;
                    if (eoi_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[0]           = (r_state == S_SERVICE);
        w_status[CODE_W:1]    = r_code;
    end

    always_comb begin
        case (cfg_addr_i)
            2'd0:    cfg_rdata_o = r_mask;
            2'd1:    cfg_rdata_o = r_edge;
            2'd2:    cfg_rdata_o = r_pend;
            default: cfg_rdata_o = w_status;
        endcase
    end

    // Vector arithmetic wraps naturally at ADDR_W bits.
    assign w_offset    = ADDR_W'(r_code) << VEC_STRIDE_LOG2;
    assign ivec_addr_o = ivt_base_i + w_offset;
    assign int_o       = r_int;
    assign intcode_o   = r_code;

endmodule

// File: tb/tb_kc_ls1u_intc.sv
// Directed and randomized checks of kc_ls1u_intc against a cycle-level behavioural model of the controller rules.
module tb_kc_ls1u_intc;

    localparam int N  = 8;
    localparam int AW = 24;
    localparam int SL = 2;
    localparam int CW = 3;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_SERV = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  irq_i = '0;
    logic [AW-1:0] ivt_base_i = 24'hFF0000;
    logic          cfg_we_i = 1'b0;
    logic [1:0]    cfg_addr_i = 2'd0;
    logic [N-1:0]  cfg_wdata_i = '0;
    logic [N-1:0]  cfg_rdata_o;
    logic          int_o;
    logic          int_ack_i = 1'b0;
    logic          eoi_i = 1'b0;
    logic [CW-1:0] intcode_o;
    logic [AW-1:0] ivec_addr_o;

    int errors = 0;
    int checks = 0;

    bit mMask [N];
    bit mEdge [N];
    bit mPend [N];
    bit mPrev [N];
    int mState;
    int mCode;
    bit mInt;

    kc_ls1u_intc #(.NUM_IRQ(N), .ADDR_W(AW), .VEC_STRIDE_LOG2(SL)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_i       (irq_i),
        .ivt_base_i  (ivt_base_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_rdata_o (cfg_rdata_o),
        .int_o       (int_o),
        .int_ack_i   (int_ack_i),
        .eoi_i       (eoi_i),
        .intcode_o   (intcode_o),
        .ivec_addr_o (ivec_addr_o)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mMask[i] = 0; mEdge[i] = 0; mPend[i] = 0; mPrev[i] = 0;
        end
        mState = M_IDLE;
        mCode  = 0;
        mInt   = 0;
    endfunction

    // One clock edge of the controller rules, using the inputs held across that edge.
    function automatic void modelStep();
        bit newPend [N];
        int firstEligible;
        bit ackTaken;
        ackTaken = (mState == M_REQ) && int_ack_i;
        for (int i = 0; i < N; i++) begin
            if (mEdge[i]) begin
                bit rise;
                bit clear;
                rise  = irq_i[i] && !mPrev[i];
                clear = (ackTaken && mCode == i) || (cfg_we_i && cfg_addr_i == 2'd2 && cfg_wdata_i[i]);
                newPend[i] = rise || (mPend[i] && !clear);
            end else begin
                newPend[i] = irq_i[i];
            end
        end
        firstEligible = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mPend[i] && mMask[i]) firstEligible = i;
        end
        if (mState == M_IDLE) begin
            if (firstEligible >= 0) begin
                mState = M_REQ; mCode = firstEligible; mInt = 1;
            end
        end else if (mState == M_REQ) begin
            if (int_ack_i) begin
                mState = M_SERV; mInt = 0;
            end else if (!(mPend[mCode] && mMask[mCode])) begin
                mState = M_IDLE; mInt = 0;
            end
        end else begin
            if (eoi_i) mState = M_IDLE;
        end
        for (int i = 0; i < N; i++) begin
            mPend[i] = newPend[i];
            mPrev[i] = irq_i[i];
            if (cfg_we_i && cfg_addr_i == 2'd0) mMask[i] = cfg_wdata_i[i];
            if (cfg_we_i && cfg_addr_i == 2'd1) mEdge[i] = cfg_wdata_i[i];
        end
    endfunction

    function automatic logic [N-1:0] expRdata();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (cfg_addr_i)
                2'd0: v[i] = mMask[i];
                2'd1: v[i] = mEdge[i];
                2'd2: v[i] = mPend[i];
                default: ;
            endcase
        end
        if (cfg_addr_i == 2'd3) v = N'(mCode * 2 + ((mState == M_SERV) ? 1 : 0));
        return v;
    endfunction

    function automatic logic [AW-1:0] expIvec();
        longint sum;
        sum = longint'(ivt_base_i) + longint'(mCode) * (longint'(1) << SL);
        return AW'(sum % (longint'(1) << AW));
    endfunction

    task automatic checkOutput(input string tag);
        logic [N-1:0]  eRd;
        logic [AW-1:0] eIv;
        logic [CW-1:0] eCode;
        eRd   = expRdata();
        eIv   = expIvec();
        eCode = CW'(mCode);
        checks++;
        assert (int_o === mInt) else begin
            errors++; $error("[TB] FAIL %s int_o: got %b expected %b", tag, int_o, mInt);
        end
        checks++;
        assert (intcode_o === eCode) else begin
            errors++; $error("[TB] FAIL %s intcode_o: got %0d expected %0d", tag, intcode_o, eCode);
        end
        checks++;
        assert (ivec_addr_o === eIv) else begin
            errors++; $error("[TB] FAIL %s ivec_addr_o: got %h expected %h", tag, ivec_addr_o, eIv);
        end
        checks++;
        assert (cfg_rdata_o === eRd) else begin
            errors++; $error("[TB] FAIL %s cfg_rdata_o[%0d]: got %h expected %h", tag, cfg_addr_i, cfg_rdata_o, eRd);
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] irq, input logic we, input logic [1:0] addr,
                                 input logic [N-1:0] wd, input logic ack, input logic eoi);
        irq_i = irq; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
        int_ack_i = ack; eoi_i = eoi;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    initial begin
        logic [N-1:0] rIrq;
        $display("[TB] kc_ls1u_intc bench start");
        modelReset();
        #12;
        checkOutput("reset");
        checkVal("reset ivec", 32'(ivec_addr_o), 32'hFF0000);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Basic edge source 3
        applyStimulus(8'h00, 1, 2'd0, 8'h08, 0, 0); checkOutput("b.mask");
        applyStimulus(8'h00, 1, 2'd1, 8'h08, 0, 0); checkOutput("b.edge");
        applyStimulus(8'h08, 0, 2'd2, 8'h00, 0, 0); checkOutput("b.rise");
        checkVal("b.noIntYet", 32'(int_o), 0);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("b.req");
        checkVal("b.int", 32'(int_o), 1);
        checkVal("b.code", 32'(intcode_o), 3);
        checkVal("b.ivec", 32'(ivec_addr_o), 32'hFF000C);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 1, 0); checkOutput("b.ack");
        checkVal("b.pendClr", 32'(cfg_rdata_o), 0);
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 1); checkOutput("b.eoi");
        checkVal("b.status", 32'(cfg_rdata_o) & 32'h1, 0);

        // Priority without preemption
        applyStimulus(8'h00, 1, 2'd0, 8'hFF, 0, 0); checkOutput("p.mask");
        applyStimulus(8'h00, 1, 2'd1, 8'hFF, 0, 0); checkOutput("p.edge");
        applyStimulus(8'h20, 0, 2'd2, 8'h00, 0, 0); checkOutput("p.rise5");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("p.req5");
        applyStimulus(8'h02, 0, 2'd2, 8'h00, 0, 0); checkOutput("p.rise1");
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 0); checkOutput("p.hold");
        checkVal("p.code5", 32'(intcode_o), 5);
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 1, 0); checkOutput("p.ack5");
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 1); checkOutput("p.eoi5");
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 0); checkOutput("p.req1");
        checkVal("p.code1", 32'(intcode_o), 1);
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 1, 0); checkOutput("p.ack1");
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 1); checkOutput("p.eoi1");

        // Set beats clear on the ack cycle
        applyStimulus(8'h10, 0, 2'd2, 8'h00, 0, 0); checkOutput("s.rise4");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("s.req4");
        applyStimulus(8'h10, 0, 2'd2, 8'h00, 1, 0); checkOutput("s.ackRise");
        checkVal("s.pend4", 32'(cfg_rdata_o), 32'h10);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 1); checkOutput("s.eoi");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("s.rereq");
        checkVal("s.int4", 32'(int_o), 1);
        checkVal("s.code4", 32'(intcode_o), 4);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 1, 0); checkOutput("s.ack2");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 1); checkOutput("s.eoi2");

        // Withdrawn level request
        applyStimulus(8'h00, 1, 2'd1, 8'hBF, 0, 0); checkOutput("w.edge");
        applyStimulus(8'h40, 0, 2'd2, 8'h00, 0, 0); checkOutput("w.level");
        applyStimulus(8'h40, 0, 2'd2, 8'h00, 0, 0); checkOutput("w.req");
        checkVal("w.int", 32'(int_o), 1);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("w.drop");
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 0); checkOutput("w.withdraw");
        checkVal("w.intLow", 32'(int_o), 0);
        applyStimulus(8'h00, 0, 2'd3, 8'h00, 1, 0); checkOutput("w.lateAck");
        checkVal("w.notServ", 32'(cfg_rdata_o) & 32'h1, 0);

        // Masked accumulation and address wrap
        applyStimulus(8'h00, 1, 2'd1, 8'hFF, 0, 0); checkOutput("m.edge");
        applyStimulus(8'h00, 1, 2'd0, 8'h00, 0, 0); checkOutput("m.mask0");
        applyStimulus(8'h80, 0, 2'd2, 8'h00, 0, 0); checkOutput("m.rise7");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("m.pend");
        checkVal("m.pend80", 32'(cfg_rdata_o), 32'h80);
        checkVal("m.noInt", 32'(int_o), 0);
        ivt_base_i = 24'hFFFFF8;
        applyStimulus(8'h00, 1, 2'd0, 8'h80, 0, 0); checkOutput("m.unmask");
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 0, 0); checkOutput("m.req7");
        checkVal("m.code7", 32'(intcode_o), 7);
        checkVal("m.wrap", 32'(ivec_addr_o), 32'h000014);
        applyStimulus(8'h00, 0, 2'd2, 8'h00, 1, 0); checkOutput("m.ack");

        // Async reset while in service
        applyStimulus(8'h01, 0, 2'd2, 8'h00, 0, 0); checkOutput("r.rise0");
        checkVal("r.pendBefore", 32'(cfg_rdata_o), 32'h01);
        irq_i = '0;
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkVal("r.intNow", 32'(int_o), 0);
        checkVal("r.pendNow", 32'(cfg_rdata_o), 0);
        cfg_addr_i = 2'd0;
        #1;
        checkVal("r.maskNow", 32'(cfg_rdata_o), 0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 0, 2'd3, 8'h00, 0, 0); checkOutput("r.quiet");
        end

        // Randomized traffic
        applyStimulus(8'h00, 1, 2'd0, N'($urandom), 0, 0); checkOutput("x.mask");
        applyStimulus(8'h00, 1, 2'd1, N'($urandom), 0, 0); checkOutput("x.edge");
        rIrq = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) rIrq[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 40) == 0) ivt_base_i = AW'($urandom);
            applyStimulus(rIrq, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), N'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            checkOutput("x.rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
